fetch_queue: RTL
================

# fetch_queue

Parametrised instruction prefetch queue between the core's fetch stage and instruction memory. It issues sequential word fetches under a credit limit and tags each returned instruction with its PC. Instructions are buffered in an in-order FIFO for the decode stage. It supports branch redirect with flush, including discard of in-flight responses, and stops fetching on a HLT opcode.

## Interface
Parameters:
- DATA_W, 32, instruction width in bits; multiple of 8, ≥ 8
- ADDR_W, 32, byte-address width
- DEPTH, 4, queue entries; power of 2, ≥ 2
- RESET_PC, 0, fetch address after reset
- HLT_OP, 4'b1111, value of instr[DATA_W-1:DATA_W-4] that halts fetch

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- imem_req_valid  out  1  fetch request
- imem_req_addr  out  ADDR_W  byte address of the request
- imem_req_ready  in  1  memory accepts the request
- imem_rsp_valid  in  1  response beat; one beat per accepted request, in order
- imem_rsp_data  in  DATA_W  returned instruction
- redirect_valid  in  1  flush the queue and restart fetch
- redirect_pc  in  ADDR_W  new fetch address
- deq_valid  out  1  queue head valid
- deq_instr  out  DATA_W  head instruction
- deq_pc  out  ADDR_W  head PC
- deq_ready  in  1  consumer takes the head
- count  out  $clog2(DEPTH+1)  current occupancy
- halted  out  1  HLT enqueued; fetch stopped

## Operation
- State:
  - fetch_pc: next request address
  - enq_pc: PC of the next response to enqueue
  - outstanding: accepted requests not yet answered, 0..DEPTH
  - drop_cnt: responses still to discard
  - FIFO of {instr, pc}
  - halted
- INC = DATA_W/8. All PC arithmetic wraps modulo 2^ADDR_W.
- Request condition: imem_req_valid = !rst & !halted & !redirect_valid & (count + outstanding + drop_cnt < DEPTH).
  - All terms are current-cycle registered values. A same-cycle dequeue frees its credit only in the next cycle.
- Handshake: a request is accepted when imem_req_valid & imem_req_ready. On acceptance, fetch_pc += INC and outstanding increments.
  - imem_req_addr = fetch_pc, stable while valid is high and ready is low.
- Response handling:
  - drop_cnt > 0: the beat is discarded and drop_cnt decrements.
  - Otherwise: {imem_rsp_data, enq_pc} is written to the FIFO tail, enq_pc += INC, and outstanding decrements.
  - A response with outstanding = 0 and drop_cnt = 0 is a protocol error and is ignored.
- HLT: when an enqueued instruction's opcode equals HLT_OP, halted is set at the next edge. In the same edge, all remaining outstanding responses move into drop_cnt: drop_cnt += outstanding, outstanding = 0. The HLT entry itself stays in the queue.
- Redirect has priority over everything else in the same cycle:
  - FIFO emptied.
  - fetch_pc and enq_pc set to redirect_pc.
  - halted cleared.
  - drop_cnt = drop_cnt + outstanding − (rsp_valid this cycle ? 1 : 0). Any response arriving in this cycle is discarded.
  - outstanding = 0.
  - A simultaneous dequeue is ignored.
- Dequeue: a pop occurs when deq_valid & deq_ready. deq_valid = (count != 0). deq_instr and deq_pc come from the head entry.
- Simultaneous enqueue and dequeue: count stays the same; head and tail pointers each advance and wrap at DEPTH.
- There is no full-queue overflow path. The credit rule guarantees the FIFO never receives a response while full.

## Timing
- Reset (rst high at posedge) produces, from the next cycle:
  - count = 0, outstanding = 0, drop_cnt = 0, halted = 0
  - deq_valid = 0, fetch_pc = enq_pc = RESET_PC
  - imem_req_valid = 0 while rst is high
- Reset mid-operation discards all FIFO contents and in-flight tracking. Memory must also be reset, because responses after reset are not dropped.
- First request: imem_req_valid rises in the first cycle after rst deasserts.
- Responses may arrive no earlier than 1 cycle after acceptance.
- Latency: a response at edge N makes deq_valid high during cycle N+1. There is no bypass path.
- Redirect at edge N: imem_req_valid is low in cycle N. The request to redirect_pc is presented in cycle N+1, subject to credits.
- halted is visible in the cycle after the HLT enqueue edge.
- Peak throughput is one instruction per cycle when response latency ≤ DEPTH − 1.

## Test plan
- Reset, ready=1, 1-cycle response latency, deq_ready=1, instructions 0x0000_0001.. → requests at 0x0, 0x4, 0x8, …; deq_pc sequence 0x0, 0x4, 0x8; deq_valid first high 2 cycles after the first request; one instruction per cycle.
- deq_ready=0, DEPTH=4 → exactly 4 requests accepted; count=4; imem_req_valid low. Then deq_ready=1 for 1 cycle → one new request at 0x10.
- 3 requests outstanding (0x20, 0x24, 0x28); redirect to 0x100 the cycle before the first response → 3 responses discarded; count stays 0; next deq_pc = 0x100.
- Response 0xF000_0000 at PC 0x8 with 2 requests still outstanding → halted=1; those 2 responses dropped; the queue drains 0x0, 0x4, 0x8; no further requests. Then redirect to 0x40 → halted=0; fetch resumes at 0x40.
- imem_req_ready=0 for 5 cycles → imem_req_addr held at the same value; fetch_pc does not advance.
- Reset asserted with count=3 and outstanding=1 → next cycle: count=0, deq_valid=0, halted=0; first request at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: credit-limited sequential fetch, PC tagging,
// in-order buffering for decode, redirect flush with in-flight discard, HLT stop.
module fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HLT_OP   = 4'b1111
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req_valid,
  output logic [ADDR_W-1:0]          imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [DATA_W-1:0]          imem_rsp_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       deq_valid,
  output logic [DATA_W-1:0]          deq_instr,
  output logic [ADDR_W-1:0]          deq_pc,
  input  logic                       deq_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted
);
  localparam int                CNT_W = $clog2(DEPTH + 1);
  localparam int                PTR_W = $clog2(DEPTH);
  localparam int                SUM_W = CNT_W + 2;
  localparam logic [ADDR_W-1:0] INC   = ADDR_W'(DATA_W / 8);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] enq_pc_q, enq_pc_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic              halted_q, halted_d;

  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem    [DEPTH];

  logic [SUM_W-1:0]  credits_used;
  logic [CNT_W-1:0]  out_after;
  logic              req_fire, rsp_drop, rsp_enq, pop, hlt_seen;

  // Queued, in-flight and to-be-dropped beats all hold a slot, so the FIFO can never overflow.
  assign credits_used   = SUM_W'(count_q) + SUM_W'(outstanding_q) + SUM_W'(drop_cnt_q);
  assign imem_req_valid = !rst && !halted_q && !redirect_valid && (credits_used < SUM_W'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign deq_valid      = (count_q != '0);
  assign deq_instr      = instr_mem[head_q];
  assign deq_pc         = pc_mem[head_q];
  assign count          = count_q;
  assign halted         = halted_q;

  always_comb begin
    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
    fetch_pc_d    = fetch_pc_q;
    enq_pc_d      = enq_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    halted_d      = halted_q;
    out_after     = outstanding_q;

    req_fire = imem_req_valid && imem_req_ready;
    rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
    rsp_enq  = imem_rsp_valid && (drop_cnt_q == '0) && (outstanding_q != '0);
    pop      = deq_valid && deq_ready;
    hlt_seen = rsp_enq && (imem_rsp_data[DATA_W-1 -: 4] == HLT_OP);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + INC;
      out_after  = out_after + CNT_W'(1);
    end
    if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    if (rsp_enq) begin
      out_after = out_after - CNT_W'(1);
      tail_d    = tail_q + PTR_W'(1);
      enq_pc_d  = enq_pc_q + INC;
    end
    if (pop) head_d = head_q + PTR_W'(1);
    count_d       = count_q + CNT_W'(rsp_enq) - CNT_W'(pop);
    outstanding_d = out_after;

    // Everything still in flight behind a HLT, including a request accepted this cycle, is discarded.
    if (hlt_seen) begin
      halted_d      = 1'b1;
      drop_cnt_d    = drop_cnt_q + out_after;
      outstanding_d = '0;
    end

    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc;
      enq_pc_d      = redirect_pc;
      halted_d      = 1'b0;
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      outstanding_d = '0;
      drop_cnt_d    = drop_cnt_q + outstanding_q;
      if (imem_rsp_valid && (drop_cnt_d != '0)) drop_cnt_d = drop_cnt_d - CNT_W'(1);
    end
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      enq_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      halted_q      <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      enq_pc_q      <= enq_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      halted_q      <= halted_d;
    end
  end

  // NOTE: storage is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (rsp_enq && !redirect_valid) begin
      instr_mem[tail_q] <= imem_rsp_data;
      pc_mem[tail_q]    <= enq_pc_q;
    end
  end
endmodule
